axi3_sink_responder: RTL
========================

Name: axi3_sink_responder

Overview:
AXI3 slave-side endpoint that answers any AXI3 master, e.g. an HBM test traffic generator, when no real memory is attached. It accepts and discards all write bursts, returning a write response per burst. It answers read bursts with a deterministic address-derived data pattern so that masters can be exercised without an HBM channel. The write and read channels run independently. Beat and error counters are exposed for debug ILA/status registers.

Parameters:
DW, 256, data width in bits; must be a multiple of 32.
IW, 6, ID width; IDs are accepted but not returned (the interface carries no BID/RID).
AW, 34, address width.

Ports:
clk  in  1  sole clock
reset  in  1  asynchronous, active-high reset
S_AXI_AWADDR  in  AW  write burst start address
S_AXI_AWLEN  in  4  beats-1
S_AXI_AWSIZE  in  3  beat size (ignored)
S_AXI_AWID  in  IW  ignored
S_AXI_AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP
S_AXI_AWVALID  in  1
S_AXI_AWREADY  out  1
S_AXI_WDATA  in  DW  discarded
S_AXI_WSTRB  in  DW/8  discarded
S_AXI_WVALID  in  1
S_AXI_WLAST  in  1
S_AXI_WREADY  out  1
S_AXI_BRESP  out  2
S_AXI_BVALID  out  1
S_AXI_BREADY  in  1
S_AXI_ARADDR  in  AW
S_AXI_ARVALID  in  1
S_AXI_ARID  in  IW  ignored
S_AXI_ARLEN  in  4
S_AXI_ARSIZE  in  3  ignored
S_AXI_ARBURST  in  2
S_AXI_ARREADY  out  1
S_AXI_RDATA  out  DW
S_AXI_RVALID  out  1
S_AXI_RRESP  out  2
S_AXI_RLAST  out  1
S_AXI_RREADY  in  1
wr_beats  out  32  total accepted W beats; wraps at 2^32
rd_beats  out  32  total delivered R beats; wraps at 2^32
err_sticky  out  1  set on any SLVERR issued; cleared only by reset

Behaviour:
Reset (asynchronous, active-high):
- All FSMs go to IDLE.
- All VALIDs, RLAST, BRESP, RRESP, RDATA, counters and err_sticky are 0.
- AWREADY and ARREADY are 1 after reset deasserts.
- Reset mid-burst abandons the burst; no response is issued for it.

Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
- W_IDLE: AWREADY=1, WREADY=0. On AWVALID, capture AWLEN and AWBURST, clear the beat counter, go to W_DATA.
- W_DATA: AWREADY=0, WREADY=1. Each WVALID&WREADY increments the beat counter and wr_beats.
- Burst error when any of: WLAST arrives before beat AWLEN; WLAST is absent on beat AWLEN; AWBURST==WRAP.
- On WLAST, or on beat AWLEN (whichever comes first), go to W_RESP.
- W_RESP: BVALID=1, BRESP=00 (OKAY), or 10 (SLVERR) if a burst error occurred. Hold until BREADY, then go to W_IDLE.
- The next AW is accepted one cycle after the B handshake. There is no AW/W overlap: W beats presented in W_IDLE stall (WREADY=0).

Read FSM, R_IDLE -> R_DATA -> R_IDLE:
- R_IDLE: ARREADY=1. On ARVALID, capture ARADDR, ARLEN and ARBURST into a beat address register; go to R_DATA.
- The first RVALID is asserted on the cycle after the AR handshake (latency 1).
- R_DATA: RVALID=1. 32-bit lane i of RDATA = beat_addr[31:0] + 4*i, for i = 0..DW/32-1.
- RLAST=1 on beat ARLEN.
- RRESP=10 on every beat if ARBURST==WRAP or 11 (reserved), otherwise 00.
- On RVALID&RREADY: increment rd_beats. For INCR or WRAP, beat_addr += DW/8 (AW-bit arithmetic, wraps at 2^AW). For FIXED, beat_addr is unchanged.
- After the last beat is handshaken, go to R_IDLE.
- RDATA, RRESP and RLAST stay stable while RVALID=1 and RREADY=0.

General:
- Read and write FSMs are independent; simultaneous AW and AR are both accepted in the same cycle.
- err_sticky is set in the cycle a SLVERR response becomes valid.

Decomposition:
- Shared package axi3_pkg: BURST_FIXED/INCR/WRAP constants, RESP_OKAY/SLVERR constants, FSM state encodings.
- One natural sub-module, axi3_sink_rd_pattern: the combinational lane-pattern generator (beat_addr -> RDATA).

Test Plan:
1. Reset, then INCR write, AWADDR=0x1000, AWLEN=3, 4 beats with WLAST on beat 3, BREADY=1 -> BVALID 1 cycle after the last beat, BRESP=00, wr_beats=4, err_sticky=0.
2. INCR read, ARADDR=0x2000, ARLEN=1, RREADY=1 -> beat0 lane0=0x2000, lane7=0x201C; beat1 lane0=0x2020 with RLAST=1; RRESP=00; rd_beats=2.
3. Write with AWLEN=3 and WLAST on beat 1 -> FSM leaves W_DATA after 2 beats, BRESP=10, err_sticky=1.
4. FIXED read, ARADDR=0x40, ARLEN=2, RREADY toggling 1/0 -> 3 beats, every beat lane0=0x40, data stable through stalls.
5. WRAP read, ARLEN=0 -> single beat, RRESP=10, RLAST=1, err_sticky=1.
6. Simultaneous AW and AR in the same cycle, then reset asserted mid-read on beat 1 -> both accepted; after reset RVALID=0, counters=0, ARREADY=1.

Source files
------------

// File: rtl/axi3_pkg.sv
// Shared constants for the AXI3 sink responder: burst/response encodings and FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi3_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // WRAP is not modelled and 2'b11 is reserved; both are answered with SLVERR.
    function automatic logic rd_burst_bad(input logic [1:0] burst);
        return (burst == BURST_WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/axi3_sink_rd_pattern.sv
// Read data pattern: 32-bit lane i carries lane_base_i + 4*i, so each lane shows its own byte address.
// Latency: purely combinational.
// Backpressure: none; the caller holds lane_base_i stable while a beat is stalled.
// Ports: lane_base_i - low 32 bits of the current beat address; rdata_o - full-width beat data.
module axi3_sink_rd_pattern #(
    parameter int DW = 256
) (
    input  logic [31:0]   lane_base_i,
    output logic [DW-1:0] rdata_o
);

    for (genvar i = 0; i < DW / 32; i++) begin : g_lane
        assign rdata_o[32*i +: 32] = lane_base_i + 32'(4 * i);
    end

endmodule

// File: rtl/axi3_sink_responder.sv
// AXI3 slave endpoint: discards write bursts with one B per burst, answers reads with an address pattern.
// Latency: BVALID one cycle after the final W beat; first RVALID one cycle after the AR handshake.
// Backpressure: B and R hold until BREADY/RREADY; no new AW/AR is taken until the current burst completes.
// Ports: S_AXI_* AXI3 slave channels (no BID/RID), wr_beats/rd_beats beat counters, err_sticky SLVERR flag.
module axi3_sink_responder
    import axi3_pkg::*;
#(
    parameter int DW = 256,
    parameter int IW = 6,
    parameter int AW = 34
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   S_AXI_AWADDR,
    input  logic [3:0]      S_AXI_AWLEN,
    input  logic [2:0]      S_AXI_AWSIZE,
    input  logic [IW-1:0]   S_AXI_AWID,
    input  logic [1:0]      S_AXI_AWBURST,
    input  logic            S_AXI_AWVALID,
    output logic            S_AXI_AWREADY,
    input  logic [DW-1:0]   S_AXI_WDATA,
    input  logic [DW/8-1:0] S_AXI_WSTRB,
    input  logic            S_AXI_WVALID,
    input  logic            S_AXI_WLAST,
    output logic            S_AXI_WREADY,
    output logic [1:0]      S_AXI_BRESP,
    output logic            S_AXI_BVALID,
    input  logic            S_AXI_BREADY,
    input  logic [AW-1:0]   S_AXI_ARADDR,
    input  logic            S_AXI_ARVALID,
    input  logic [IW-1:0]   S_AXI_ARID,
    input  logic [3:0]      S_AXI_ARLEN,
    input  logic [2:0]      S_AXI_ARSIZE,
    input  logic [1:0]      S_AXI_ARBURST,
    output logic            S_AXI_ARREADY,
    output logic [DW-1:0]   S_AXI_RDATA,
    output logic            S_AXI_RVALID,
    output logic [1:0]      S_AXI_RRESP,
    output logic            S_AXI_RLAST,
    input  logic            S_AXI_RREADY,
    output logic [31:0]     wr_beats,
    output logic [31:0]     rd_beats,
    output logic            err_sticky
);

    logic [1:0]    w_state_q, w_state_d;
    logic [3:0]    w_len_q, w_len_d;
    logic [3:0]    w_cnt_q, w_cnt_d;
    logic          w_err_q, w_err_d;
    logic [31:0]   wr_beats_q, wr_beats_d;

    logic [0:0]    r_state_q, r_state_d;
    logic [AW-1:0] r_addr_q, r_addr_d;
    logic [3:0]    r_len_q, r_len_d;
    logic [3:0]    r_cnt_q, r_cnt_d;
    logic [1:0]    r_burst_q, r_burst_d;
    logic [31:0]   rd_beats_q, rd_beats_d;

    logic          err_sticky_q, err_sticky_d;
    logic          w_final_beat;
    logic          w_len_mismatch;
    logic [DW-1:0] pattern;

    // Address, IDs, sizes and write payload are deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWADDR, S_AXI_AWSIZE, S_AXI_AWID, S_AXI_WDATA,
                             S_AXI_WSTRB, S_AXI_ARID, S_AXI_ARSIZE};

    assign w_final_beat   = (w_cnt_q == w_len_q);
    // WLAST must coincide exactly with beat AWLEN; either side arriving alone is a burst error.
    assign w_len_mismatch = S_AXI_WLAST != w_final_beat;

    always_comb begin
        w_state_d    = w_state_q;
        w_len_d      = w_len_q;
        w_cnt_d      = w_cnt_q;
        w_err_d      = w_err_q;
        wr_beats_d   = wr_beats_q;
        r_state_d    = r_state_q;
        r_addr_d     = r_addr_q;
        r_len_d      = r_len_q;
        r_cnt_d      = r_cnt_q;
        r_burst_d    = r_burst_q;
        rd_beats_d   = rd_beats_q;
        err_sticky_d = err_sticky_q;

        case (w_state_q)
            W_IDLE: begin
                if (S_AXI_AWVALID) begin
                    w_len_d   = S_AXI_AWLEN;
                    w_cnt_d   = 4'd0;
                    w_err_d   = (S_AXI_AWBURST == BURST_WRAP);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (S_AXI_WVALID) begin
                    wr_beats_d = wr_beats_q + 32'd1;
                    w_cnt_d    = w_cnt_q + 4'd1;
                    if (S_AXI_WLAST || w_final_beat) begin
                        w_state_d = W_RESP;
                        w_err_d   = w_err_q | w_len_mismatch;
                        // Set on the same edge that raises BVALID with SLVERR.
                        if (w_err_q || w_len_mismatch) begin
                            err_sticky_d = 1'b1;
                        end
                    end
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        case (r_state_q)
            R_IDLE: begin
                if (S_AXI_ARVALID) begin
                    r_addr_d  = S_AXI_ARADDR;
                    r_len_d   = S_AXI_ARLEN;
                    r_burst_d = S_AXI_ARBURST;
                    r_cnt_d   = 4'd0;
                    r_state_d = R_DATA;
                    if (rd_burst_bad(S_AXI_ARBURST)) begin
                        err_sticky_d = 1'b1;
                    end
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rd_beats_d = rd_beats_q + 32'd1;
                    r_cnt_d    = r_cnt_q + 4'd1;
                    if (r_burst_q != BURST_FIXED) begin
                        r_addr_d = r_addr_q + AW'(DW / 8);
                    end
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q    <= W_IDLE;
            w_len_q      <= 4'd0;
            w_cnt_q      <= 4'd0;
            w_err_q      <= 1'b0;
            wr_beats_q   <= 32'd0;
            r_state_q    <= R_IDLE;
            r_addr_q     <= '0;
            r_len_q      <= 4'd0;
            r_cnt_q      <= 4'd0;
            r_burst_q    <= BURST_FIXED;
            rd_beats_q   <= 32'd0;
            err_sticky_q <= 1'b0;
        end else begin
            w_state_q    <= w_state_d;
            w_len_q      <= w_len_d;
            w_cnt_q      <= w_cnt_d;
            w_err_q      <= w_err_d;
            wr_beats_q   <= wr_beats_d;
            r_state_q    <= r_state_d;
            r_addr_q     <= r_addr_d;
            r_len_q      <= r_len_d;
            r_cnt_q      <= r_cnt_d;
            r_burst_q    <= r_burst_d;
            rd_beats_q   <= rd_beats_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    axi3_sink_rd_pattern #(.DW(DW)) u_pattern (
        .lane_base_i (r_addr_q[31:0]),
        .rdata_o     (pattern)
    );

    assign S_AXI_AWREADY = (w_state_q == W_IDLE);
    assign S_AXI_WREADY  = (w_state_q == W_DATA);
    assign S_AXI_BVALID  = (w_state_q == W_RESP);
    assign S_AXI_BRESP   = (S_AXI_BVALID && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    // Read outputs are forced to zero outside a burst; inside, they depend only on
    // registered state, so they stay stable while RREADY is low.
    assign S_AXI_ARREADY = (r_state_q == R_IDLE);
    assign S_AXI_RVALID  = (r_state_q == R_DATA);
    assign S_AXI_RLAST   = S_AXI_RVALID && (r_cnt_q == r_len_q);
    assign S_AXI_RRESP   = (S_AXI_RVALID && rd_burst_bad(r_burst_q)) ? RESP_SLVERR : RESP_OKAY;
    assign S_AXI_RDATA   = S_AXI_RVALID ? pattern : '0;

    assign wr_beats   = wr_beats_q;
    assign rd_beats   = rd_beats_q;
    assign err_sticky = err_sticky_q;

endmodule
